// File: rtl/aes_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_job_sequencer
// Purpose  : Runs one job at a time through an external AES core and queues
//            tagged results (OK or timeout) in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module aes_job_sequencer #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int RES_DEPTH      = 4
) (
   input  logic        clk_main_a0,
   input  logic        rst_main_n_sync,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_key,
   input  logic [3:0]  cmd_data,
   output logic        aes_rst,
   output logic [3:0]  aes_key_in,
   output logic [3:0]  aes_d_in,
   input  logic [4:0]  aes_d_out,
   input  logic        aes_d_vld,
   input  logic        res_rd,
   output logic [31:0] res_dout,
   output logic        res_empty,
   output logic        busy,
   output logic        timeout_err,
   input  logic        clear_err,
   output logic [15:0] job_count
);

   localparam int c_ptr_w = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int c_cnt_w = $clog2(RES_DEPTH + 1);
   localparam int c_tmr_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(RES_DEPTH);
   localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RUN     = 3'd2,
      S_STORE   = 3'd3,
      S_RECOVER = 3'd4
   } state_t;

   state_t               r_state;
   logic [c_tmr_w-1:0]   r_timer;
   logic [4:0]           r_d_out;
   logic [15:0]          r_job_count;
   logic                 r_cmd_ready;
   logic                 r_aes_rst;
   logic                 r_busy;
   logic                 r_timeout_err;
   logic [3:0]           r_key;
   logic [3:0]           r_data;

   logic [31:0]          r_mem [RES_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;

   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_room;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic [31:0]          w_push_data;

   assign w_accept  = cmd_valid && r_cmd_ready;
   assign w_push    = (r_state == S_STORE) || (r_state == S_RECOVER);
   assign w_pop     = res_rd && (r_count != '0);
   assign w_room    = (w_cnt_nxt < c_depth);

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_push && !w_pop) begin
         w_cnt_nxt = r_count + c_cnt_w'(1);
      end else if (!w_push && w_pop) begin
         w_cnt_nxt = r_count - c_cnt_w'(1);
      end
   end

   // The tag byte is the pre-increment job count, so ids start at 0.
   always_comb begin
      w_push_data = {16'h0000, r_job_count[7:0], 3'b000, r_d_out};
      if (r_state == S_RECOVER) begin
         w_push_data = {1'b1, 15'h0000, r_job_count[7:0], 8'h00};
      end
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
      if (!rst_main_n_sync) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_d_out       <= '0;
         r_job_count   <= '0;
         r_cmd_ready   <= 1'b0;
         r_aes_rst     <= 1'b1;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_key         <= '0;
         r_data        <= '0;
      end else begin
         // A timeout set later in this block overrides a same-cycle clear.
         if (clear_err) begin
            r_timeout_err <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_LOAD;
                  r_key       <= cmd_key;
                  r_data      <= cmd_data;
                  r_aes_rst   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_cmd_ready <= 1'b0;
               end else begin
                  r_aes_rst   <= 1'b0;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= w_room;
               end
            end
            S_LOAD: begin
               r_state   <= S_RUN;
               r_aes_rst <= 1'b0;
               r_timer   <= '0;
            end
            S_RUN: begin
               if (aes_d_vld) begin
                  r_state <= S_STORE;
                  r_d_out <= aes_d_out;
               end else if (r_timer == c_tmr_last) begin
                  r_state       <= S_RECOVER;
                  r_timeout_err <= 1'b1;
                  r_aes_rst     <= 1'b1;
               end else begin
                  r_timer <= r_timer + c_tmr_w'(1);
               end
            end
            S_STORE, S_RECOVER: begin
               r_state     <= S_IDLE;
               r_aes_rst   <= 1'b0;
               r_busy      <= 1'b0;
               r_cmd_ready <= w_room;
               r_job_count <= r_job_count + 16'd1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_aes_rst   <= 1'b0;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b0;
            end
         endcase
      end
   end

   // Storage needs no reset: res_dout is masked to zero while empty.
   always_ff @(posedge clk_main_a0) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
      if (!rst_main_n_sync) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         r_count <= w_cnt_nxt;
      end
   end

   assign res_empty   = (r_count == '0);
   assign res_dout    = res_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
   assign cmd_ready   = r_cmd_ready;
   assign aes_rst     = r_aes_rst;
   assign aes_key_in  = r_key;
   assign aes_d_in    = r_data;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
   assign job_count   = r_job_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_job_sequencer
// Purpose  : Directed scoreboard bench for aes_job_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_job_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_key = '0;
   logic [3:0]  cmd_data = '0;
   logic        aes_rst;
   logic [3:0]  aes_key_in;
   logic [3:0]  aes_d_in;
   logic [4:0]  aes_d_out = '0;
   logic        aes_d_vld = 1'b0;
   logic        res_rd = 1'b0;
   logic [31:0] res_dout;
   logic        res_empty;
   logic        busy;
   logic        timeout_err;
   logic        clear_err = 1'b0;
   logic [15:0] job_count;

   int          checks = 0;
   int          errors = 0;
   int          n_pops = 0;
   int          exp_pops = 0;
   int          exp_occ = 0;
   logic [15:0] exp_jobs = '0;
   logic        exp_terr = 1'b0;
   logic [31:0] sb [$];

   aes_job_sequencer #(.TIMEOUT_CYCLES(64), .RES_DEPTH(4)) dut (
      .clk_main_a0     (clk),
      .rst_main_n_sync (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_key         (cmd_key),
      .cmd_data        (cmd_data),
      .aes_rst         (aes_rst),
      .aes_key_in      (aes_key_in),
      .aes_d_in        (aes_d_in),
      .aes_d_out       (aes_d_out),
      .aes_d_vld       (aes_d_vld),
      .res_rd          (res_rd),
      .res_dout        (res_dout),
      .res_empty       (res_empty),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .clear_err       (clear_err),
      .job_count       (job_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Monitor: every real pop is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && res_rd && !res_empty) begin
         n_pops++;
         if (sb.size() == 0) begin
            chk("unexpected_pop", res_dout, 32'hDEAD_BEEF);
         end else begin
            chk("res_dout", res_dout, sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      res_rd = 1'b1;
      tick();
      res_rd = 1'b0;
      if (exp_occ > 0) begin
         exp_occ--;
         exp_pops++;
      end
      chk1("pop_cmd_ready", cmd_ready, exp_occ < 4);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         chk1("drain_not_empty", res_empty, 1'b0);
         pop_one();
      end
      chk1("drain_empty", res_empty, 1'b1);
   endtask

   task automatic run_job(input logic [3:0] key, input logic [3:0] data,
                          input logic [4:0] dout, input int n_wait, input bit vld,
                          input bit pop_at_push, input bit clr_at_set);
      if (vld) sb.push_back({16'h0000, exp_jobs[7:0], 3'b000, dout});
      else     sb.push_back({1'b1, 15'h0000, exp_jobs[7:0], 8'h00});
      cmd_valid = 1'b1;
      cmd_key   = key;
      cmd_data  = data;
      tick();
      cmd_valid = 1'b0;
      chk1("load_aes_rst", aes_rst, 1'b1);
      chk("load_key", {28'b0, aes_key_in}, {28'b0, key});
      chk("load_data", {28'b0, aes_d_in}, {28'b0, data});
      chk1("load_cmd_ready", cmd_ready, 1'b0);
      chk1("load_busy", busy, 1'b1);
      tick();
      chk1("run_aes_rst", aes_rst, 1'b0);
      repeat (n_wait) tick();
      chk1("run_busy", busy, 1'b1);
      chk1("run_terr", timeout_err, exp_terr);
      if (vld) begin
         aes_d_vld = 1'b1;
         aes_d_out = dout;
      end
      if (clr_at_set) clear_err = 1'b1;
      tick();
      aes_d_vld = 1'b0;
      if (vld) begin
         chk1("store_aes_rst", aes_rst, 1'b0);
         chk1("store_terr", timeout_err, exp_terr);
      end else begin
         chk1("recover_aes_rst", aes_rst, 1'b1);
         chk1("recover_terr", timeout_err, 1'b1);
         exp_terr = clr_at_set ? 1'b0 : 1'b1;
      end
      if (pop_at_push) res_rd = 1'b1;
      tick();
      res_rd    = 1'b0;
      clear_err = 1'b0;
      exp_jobs++;
      exp_occ++;
      if (pop_at_push) begin
         exp_occ--;
         exp_pops++;
      end
      chk("job_count", {16'b0, job_count}, {16'b0, exp_jobs});
      chk1("push_not_empty", res_empty, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_aes_rst", aes_rst, 1'b0);
      chk1("idle_cmd_ready", cmd_ready, exp_occ < 4);
      chk1("idle_terr", timeout_err, exp_terr);
   endtask

   task automatic chk_reset_state(input string tag);
      chk1({tag, "_res_empty"}, res_empty, 1'b1);
      chk({tag, "_res_dout"}, res_dout, 32'h0);
      chk1({tag, "_cmd_ready"}, cmd_ready, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_aes_rst"}, aes_rst, 1'b1);
      chk({tag, "_key_data"}, {24'b0, aes_key_in, aes_d_in}, 32'h0);
      chk1({tag, "_terr"}, timeout_err, 1'b0);
      chk({tag, "_job_count"}, {16'b0, job_count}, 32'h0);
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #3 rst_n = 1'b0;
      #1 chk_reset_state("por");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk1("rel_cmd_ready", cmd_ready, 1'b1);
      chk1("rel_aes_rst", aes_rst, 1'b0);

      // Core valid outside RUN is ignored.
      aes_d_vld = 1'b1;
      aes_d_out = 5'h1F;
      tick();
      tick();
      aes_d_vld = 1'b0;
      chk1("idle_vld_busy", busy, 1'b0);
      chk1("idle_vld_empty", res_empty, 1'b1);

      // Basic job: d_vld four cycles after accept.
      run_job(4'h3, 4'h5, 5'h08, 2, 1'b1, 1'b0, 1'b0);
      drain(1);

      // Timeout, then explicit clear.
      run_job(4'hA, 4'h6, 5'h00, 63, 1'b0, 1'b0, 1'b0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      exp_terr  = 1'b0;
      chk1("clear_err", timeout_err, 1'b0);
      drain(1);

      // Timeout with clear_err asserted on the setting edge.
      run_job(4'h1, 4'h2, 5'h00, 63, 1'b0, 1'b0, 1'b1);
      drain(1);

      // d_vld on the final timeout cycle wins.
      run_job(4'h7, 4'h9, 5'h1F, 63, 1'b1, 1'b0, 1'b0);
      chk1("late_vld_terr", timeout_err, 1'b0);
      drain(1);

      // Fill the FIFO; accept must be refused until a pop.
      run_job(4'h1, 4'h1, 5'h01, 0, 1'b1, 1'b0, 1'b0);
      run_job(4'h2, 4'h2, 5'h02, 1, 1'b1, 1'b0, 1'b0);
      run_job(4'h3, 4'h3, 5'h03, 3, 1'b1, 1'b0, 1'b0);
      run_job(4'h4, 4'h4, 5'h04, 5, 1'b1, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      tick();
      tick();
      cmd_valid = 1'b0;
      chk1("full_no_accept", busy, 1'b0);
      pop_one();
      drain(3);
      pop_one();
      chk1("empty_pop_ignored", res_empty, 1'b1);

      // Pop concurrent with a STORE push at occupancy 2.
      run_job(4'h5, 4'h5, 5'h11, 1, 1'b1, 1'b0, 1'b0);
      run_job(4'h6, 4'h6, 5'h12, 1, 1'b1, 1'b0, 1'b0);
      run_job(4'h7, 4'h7, 5'h13, 1, 1'b1, 1'b1, 1'b0);
      drain(2);

      // Reset mid-job with a queued entry and sticky error pending.
      run_job(4'hE, 4'hF, 5'h00, 63, 1'b0, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      cmd_key   = 4'h9;
      cmd_data  = 4'h6;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1 chk_reset_state("mid");
      sb.delete();
      exp_jobs = '0;
      exp_occ  = 0;
      exp_terr = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk1("rel2_cmd_ready", cmd_ready, 1'b1);
      chk1("rel2_aes_rst", aes_rst, 1'b0);
      run_job(4'hC, 4'h3, 5'h15, 5, 1'b1, 1'b0, 1'b0);
      drain(1);

      chk("pop_count", n_pops, exp_pops);
      chk("sb_left", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_job_sequencer.md
AES_JOB_SEQUENCER -- requirements
Module: aes_job_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: RUN cycles allowed before a job is aborted.
REQ-002 SHALL have parameter RES_DEPTH, default 4: result FIFO entries (power of two).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_main_a0  in  1  rising-edge clock.
REQ-005 SHALL have port rst_main_n_sync  in  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid  in  1  job request.
REQ-007 SHALL have port cmd_ready  out  1  job accepted on the edge where cmd_valid&cmd_ready.
REQ-008 SHALL have port cmd_key  in  4  key for the job.
REQ-009 SHALL have port cmd_data  in  4  data for the job.
REQ-010 SHALL have port aes_rst  out  1  active-high reset to the AES core.
REQ-011 SHALL have port aes_key_in  out  4  core key input.
REQ-012 SHALL have port aes_d_in  out  4  core data input.
REQ-013 SHALL have port aes_d_out  in  5  core result.
REQ-014 SHALL have port aes_d_vld  in  1  core result valid.
REQ-015 SHALL have port res_rd  in  1  pop the result FIFO head.
REQ-016 SHALL have port res_dout  out  32  FIFO head, first-word fall-through.
REQ-017 SHALL have port res_empty  out  1  FIFO empty.
REQ-018 SHALL have port busy  out  1  state != IDLE.
REQ-019 SHALL have port timeout_err  out  1  sticky timeout flag.
REQ-020 SHALL have port clear_err  in  1  clears timeout_err.
REQ-021 SHALL have port job_count  out  16  jobs completed, both OK and timed out; wraps.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, RUN, STORE, RECOVER.
REQ-023 SHALL assert cmd_ready only in IDLE with FIFO occupancy < RES_DEPTH.
REQ-024 On accept, SHALL register cmd_key/cmd_data into aes_key_in/aes_d_in, holding both until the next accept, and SHALL go to LOAD.
REQ-025 SHALL hold aes_rst=1 for exactly the one LOAD cycle, then go to RUN with the timer cleared.
REQ-026 In RUN, SHALL sample aes_d_vld; when it is 1, SHALL capture aes_d_out and go to STORE; aes_d_vld outside RUN is ignored.
REQ-027 In RUN without aes_d_vld, SHALL increment the timer; when the timer reaches TIMEOUT_CYCLES-1 without aes_d_vld, SHALL set timeout_err and go to RECOVER.
REQ-028 d_vld and timeout in the same cycle: d_vld wins and the job completes OK.
REQ-029 STORE SHALL push {1'b0, 15'b0, job_id[7:0], 3'b0, d_out[4:0]}, increment job_count and go to IDLE.
REQ-030 RECOVER SHALL assert aes_rst for one cycle, push {1'b1, 15'b0, job_id[7:0], 8'b0}, increment job_count and go to IDLE.
REQ-031 job_id SHALL be the low 8 bits of job_count at the time of the push.
REQ-032 A push SHALL be visible on res_dout, with res_empty=0, in the cycle after STORE or RECOVER.
REQ-033 res_rd while empty SHALL be ignored; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-034 An overflowing push SHALL be impossible, guaranteed by REQ-023 with one job in flight.
REQ-035 clear_err SHALL clear timeout_err; if set and clear occur in the same cycle, set wins.
REQ-036 Pointers SHALL wrap modulo RES_DEPTH; job_count SHALL wrap 0xFFFF->0x0000.

Reset
REQ-037 Reset assertion SHALL immediately, asynchronously and mid-job, force: state=IDLE, FIFO empty, res_empty=1, res_dout=0, cmd_ready=0, busy=0, aes_rst=1, aes_key_in=0, aes_d_in=0, timeout_err=0, job_count=0, timer=0.
REQ-038 Any in-flight job SHALL be discarded on reset; after release, aes_rst=0 and cmd_ready=1 from the first clock edge.

Verification
REQ-039 Accept key=3, data=5 at cycle 0; core returns d_vld with d_out=0x08 at cycle 4 -> aes_rst=1 at cycle 1 only; res_dout=0x00000008, job_count=1.
REQ-040 Core never asserts d_vld, TIMEOUT_CYCLES=64 -> timeout_err=1 after 64 RUN cycles; aes_rst pulses in RECOVER; res_dout=0x80000000; job_count=1; clear_err returns timeout_err to 0.
REQ-041 Four jobs with no res_rd -> cmd_ready=0 after the fourth push; one res_rd pops job_id 0 and cmd_ready returns to 1.
REQ-042 res_rd in the same cycle as a STORE push with occupancy 2 -> occupancy remains 2; pop order is job_ids 0, 1, 2.
REQ-043 rst_main_n_sync low during RUN -> outputs match REQ-037 before the next edge; a job accepted after release completes normally with job_id 0.
REQ-044 d_vld on the final timeout cycle -> OK entry pushed, timeout_err stays 0.
